// File: rtl/barrel_iter_shift_if.sv
// Operand/result handshake bundle for barrel_iter_shift.
// The master side issues operations and consumes results.
// The slave side is the shifter itself.
interface barrel_iter_shift_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [7:0]  in_cmd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_fill;

    modport master (
        output in_valid, in_a, in_cmd, out_ready,
        input  in_ready, out_valid, out_data, out_fill
    );

    modport slave (
        input  in_valid, in_a, in_cmd, out_ready,
        output in_ready, out_valid, out_data, out_fill
    );
endinterface

// File: rtl/barrel_iter_shift.sv
// Iterative 32-bit shifter/rotator with an inverse-op option and per-bit fill tracking.
// It takes one operation at a time and runs five fixed stages of 16/8/4/2/1 positions.
// A stage only shifts when its amount bit is set, so the latency never depends on the amount.
// out_fill marks every result bit that came from zero or sign fill instead of from the operand.
module barrel_iter_shift (
    input  logic                 clk,
    input  logic                 rst_n,
    barrel_iter_shift_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Effective operation after the inverse bit has been applied.
    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROR = 3'd3,
        OP_ROL = 3'd4
    } op_t;

    state_t      state_q, state_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] fill_q,  fill_d;
    op_t         op_q,    op_d;
    logic [4:0]  amt_q,   amt_d;
    logic        sign_q,  sign_d;
    logic [2:0]  stage_q, stage_d;

    // Stage datapath signals.
    logic [5:0]  step_k;
    logic [2:0]  step_bit;
    logic        step_en;
    logic [31:0] lo_ones;
    logic [31:0] hi_ones;
    logic [31:0] step_data;
    logic [31:0] step_fill;

    // Map {inverse, op} to the operation that is actually executed.
    // The inverse of a right shift is a left shift, whether it was logical or arithmetic.
    function automatic op_t eff_op(input logic [2:0] cmd_hi);
        op_t r;
        case (cmd_hi)
            3'b000:  r = OP_SLL;
            3'b001:  r = OP_SRL;
            3'b010:  r = OP_SRA;
            3'b011:  r = OP_ROR;
            3'b100:  r = OP_SRL;
            3'b101:  r = OP_SLL;
            3'b110:  r = OP_SLL;
            default: r = OP_ROL;
        endcase
        return r;
    endfunction

    // Handshake outputs come straight from the state register.
    // The results come straight from the working registers.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = data_q;
    assign bus.out_fill  = fill_q;

    // One stage of shifting: distance 16 >> stage, enabled by amount bit (4 - stage).
    always_comb begin
        step_k    = 6'd16 >> stage_q;
        step_bit  = 3'd4 - stage_q;
        step_en   = amt_q[step_bit];
        lo_ones   = (32'd1 << step_k) - 32'd1;
        hi_ones   = ~(32'hFFFF_FFFF >> step_k);
        step_data = data_q;
        step_fill = fill_q;
        case (op_q)
            OP_SLL: begin
                step_data = data_q << step_k;
                step_fill = (fill_q << step_k) | lo_ones;
            end
            OP_SRL: begin
                step_data = data_q >> step_k;
                step_fill = (fill_q >> step_k) | hi_ones;
            end
            OP_SRA: begin
                step_data = (data_q >> step_k) | ({32{sign_q}} & hi_ones);
                step_fill = (fill_q >> step_k) | hi_ones;
            end
            OP_ROR: begin
                step_data = (data_q >> step_k) | (data_q << (6'd32 - step_k));
            end
            OP_ROL: begin
                step_data = (data_q << step_k) | (data_q >> (6'd32 - step_k));
            end
            default: begin
                step_data = data_q;
            end
        endcase
    end

    // Next-state logic: accept in IDLE, run five stages in SHIFT, hold in DONE until taken.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        fill_d  = fill_q;
        op_d    = op_q;
        amt_d   = amt_q;
        sign_d  = sign_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_a;
                    fill_d  = '0;
                    op_d    = eff_op(bus.in_cmd[7:5]);
                    amt_d   = bus.in_cmd[4:0];
                    sign_d  = bus.in_a[31];
                    stage_d = 3'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (step_en) begin
                    data_d = step_data;
                    fill_d = step_fill;
                end
                if (stage_q == 3'd4) begin
                    state_d = ST_DONE;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and working registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            fill_q  <= '0;
            op_q    <= OP_SLL;
            amt_q   <= '0;
            sign_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            sign_q  <= sign_d;
            stage_q <= stage_d;
        end
    end

endmodule

// File: doc/barrel_iter_shift.md
# barrel_iter_shift

- Sequential, handshaked companion to the combinational `barrel` shifter. It applies one 32-bit shift or rotate, or its inverse, over five clocked stages of 16/8/4/2/1 bit positions.
- It sits on the path that consumes shifter results. It restores operands for checking, and it reports which result bits are fill bits rather than data bits.
- Input and output each use a valid/ready handshake. One operation is in flight at a time.

## Interface
Parameters:
- none. Width is fixed at 32 data bits and an 8-bit command.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_a`/`in_cmd` are valid.
- `in_ready`  out  1  the block can accept an operation.
- `in_a`  in  32  operand.
- `in_cmd`  in  8  command:
  - `[4:0]` shift amount, 0-31.
  - `[6:5]` op: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
  - `[7]` 1 = apply the inverse op.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  the consumer takes the result.
- `out_data`  out  32  result.
- `out_fill`  out  32  per-bit flag; 1 = the `out_data` bit was produced by fill (zero or sign), not by an input bit.

## Operation
Effective op:
- When `cmd[7]`=0 the op is `cmd[6:5]` unchanged.
- When `cmd[7]`=1 the inverse is used: SLL→SRL, SRL→SLL, SRA→SLL, ROR→ROL.

States:
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&&`in_ready`: load `data`←`in_a`, `fill`←0, and latch the effective op, the amount and `sign`←`in_a[31]`.
  - Set `stage`←0 and go to SHIFT.
- SHIFT:
  - `in_ready`=0, `out_valid`=0.
  - Each cycle, if `amt[4-stage]`=1, shift `data` and `fill` by 2^(4-stage).
  - When `stage`=4, go to DONE; otherwise increment `stage`.
  - Every stage is executed, including amount 0, so latency is fixed.
- DONE:
  - `out_valid`=1.
  - `out_data`/`out_fill` are held stable until `out_valid`&&`out_ready`, then go to IDLE.
  - `in_ready`=0 while in DONE; there is no same-cycle re-accept.

Per-stage shift rules, with k = stage distance:
- SLL: `data`←`data`<<k, zero-filled; `fill`←(`fill`<<k) | low k ones.
- SRL: `data`←`data`>>k, zero-filled; `fill`←(`fill`>>k) | high k ones.
- SRA: as SRL, but vacated bits take the latched `sign`; `fill` behaves as for SRL.
- ROR/ROL: rotate `data` by k; `fill` stays 0.

Other rules:
- `in_valid` seen outside IDLE is ignored; the input is not consumed.
- Inputs are sampled only at the accept edge. Later changes to `in_a`/`in_cmd` have no effect.
- `out_data`/`out_fill` are driven from the working registers and are meaningful only while `out_valid`=1.

## Timing
- Reset (`rst_n`=0, at any time, including mid-SHIFT or in DONE):
  - State → IDLE at once, without waiting for `clk`.
  - `in_ready`=1, `out_valid`=0.
  - `out_data`=0, `out_fill`=0, `stage`=0.
  - Any pending operation is discarded.
- Accept at edge E0. The stages run at E1..E5. `out_valid` rises after E5, so latency is 5 cycles from the accept edge, independent of the amount.
- Minimum initiation interval is 7 cycles: accept, 5 shift cycles, and 1 DONE cycle with `out_ready`=1. IDLE is re-entered at the handshake edge, and the next accept is possible one edge later.
- Backpressure: DONE holds for any number of cycles. Outputs must not change and `in_ready` stays 0.
- Boundaries:
  - Amount 0: `out_data`=`in_a` and `out_fill`=0 for every op.
  - Amount 31 SRA of a negative operand: `out_data`=0xFFFFFFFF, `out_fill`=0xFFFFFFFE.

## Test plan
1. Reset: hold `rst_n`=0, then release with no stimulus → `in_ready`=1, `out_valid`=0, `out_data`=0, `out_fill`=0. Then assert `rst_n`=0 mid-SHIFT, on the 3rd cycle → outputs return to these values immediately and no result appears afterwards.
2. Forward SLL: `a`=0x80000001, `cmd`=0x03 → 5 cycles after accept, `out_data`=0x00000008, `out_fill`=0x00000007.
3. Rotate round trip: `a`=0x12345678, `cmd`=0x64 → 0x81234567 with `out_fill`=0. Then `a`=0x81234567, `cmd`=0xE4 → 0x12345678.
4. SRA and its inverse:
   - `a`=0xF0000000, `cmd`=0x48 → 0xFFF00000, `out_fill`=0xFF000000.
   - `a`=0xFFF00000, `cmd`=0xC8 → 0xF0000000, `out_fill`=0x000000FF.
5. Backpressure: hold `out_ready`=0 for 3 cycles in DONE while driving a new `in_valid` → outputs stable, `in_ready`=0, new operation not accepted. After the handshake, the new operation is accepted one edge later.
6. Boundaries:
   - `cmd`=0x00 and 0x60 with `a`=0xDEADBEEF → output unchanged, `out_fill`=0.
   - `a`=0x80000000, `cmd`=0x5F → 0xFFFFFFFF, `out_fill`=0xFFFFFFFE.
